// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit.
// Walks the PC, fetches one word at a time over a req/ack handshake, hands
// each word to decode over valid/ready, and resolves 'j' locally. A redirect
// from downstream discards in-flight or held work and restarts the fetch.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [5:0] OP_J = 6'b00_0010;

  // Target of a 'j': the region bits come from the address after the jump.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] word);
    return {pc4[31:28], word[25:0], 2'b00};
  endfunction

  state_t      state_r, state_s;
  logic [31:0] addr_r, addr_s;        // address of the current/next request
  logic [31:0] next_pc_r, next_pc_s;  // fetch address following the held word
  logic [31:0] save_pc_r, save_pc_s;  // redirect target parked during DRAIN
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc4_r, pc4_s;
  logic [31:0] count_r, count_s;
  logic        req_r, valid_r;
  logic [31:0] redirect_addr_s;
  logic [31:0] fetch_pc4_s;
  logic        unused_s;

  // Low address bits of a redirect are forced to zero to keep fetches aligned.
  assign redirect_addr_s = {redirect_pc[31:2], 2'b00};
  assign fetch_pc4_s     = addr_r + 32'd4;
  assign unused_s        = ^redirect_pc[1:0];

  // Next-state and datapath update; redirect takes priority in every state.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    next_pc_s = next_pc_r;
    save_pc_s = save_pc_r;
    instr_s   = instr_r;
    pc4_s     = pc4_r;
    count_s   = count_r;
    case (state_r)
      IDLE: begin
        state_s = REQ;
        if (redirect) begin
          addr_s = redirect_addr_s;
        end else begin
          addr_s = RESET_PC;
        end
      end
      REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            // Returning word is dropped; restart straight away.
            state_s = REQ;
            addr_s  = redirect_addr_s;
          end else begin
            // Request still outstanding: let it finish before restarting.
            state_s   = DRAIN;
            save_pc_s = redirect_addr_s;
          end
        end else if (imem_ack) begin
          state_s = HOLD;
          instr_s = imem_rdata;
          pc4_s   = fetch_pc4_s;
          if (imem_rdata[31:26] == OP_J) begin
            next_pc_s = jump_target(fetch_pc4_s, imem_rdata);
          end else begin
            next_pc_s = fetch_pc4_s;
          end
        end else begin
          state_s = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_s = REQ;
          addr_s  = redirect_addr_s;
        end else if (instr_ready) begin
          state_s = REQ;
          addr_s  = next_pc_r;
          count_s = count_r + 32'd1;
        end else begin
          state_s = HOLD;
        end
      end
      DRAIN: begin
        if (redirect) begin
          save_pc_s = redirect_addr_s;
        end else begin
          save_pc_s = save_pc_r;
        end
        if (imem_ack) begin
          state_s = REQ;
          if (redirect) begin
            addr_s = redirect_addr_s;
          end else begin
            addr_s = save_pc_r;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      addr_r    <= RESET_PC;
      next_pc_r <= RESET_PC;
      save_pc_r <= RESET_PC;
      instr_r   <= 32'd0;
      pc4_r     <= 32'd0;
      count_r   <= 32'd0;
      req_r     <= 1'b0;
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      next_pc_r <= next_pc_s;
      save_pc_r <= save_pc_s;
      instr_r   <= instr_s;
      pc4_r     <= pc4_s;
      count_r   <= count_s;
      req_r     <= (state_s == REQ) || (state_s == DRAIN);
      valid_r   <= (state_s == HOLD);
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign instr_pc4   = pc4_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch with a request/acceptance scoreboard.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } acc_t;

  logic [31:0] exp_addr_q[$];
  acc_t        exp_acc_q[$];
  int          checks = 0;
  int          failures = 0;
  int          ack_delay = 0;
  int          req_cnt = 0;
  logic        force_ack = 1'b0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc4   (instr_pc4),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: two 'j' words, everything else a non-jump pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000 || a == 32'hF000_0000) return 32'h0800_0010;
    return a ^ 32'hA500_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic [31:0] w, input logic [31:0] p, input logic [31:0] c);
    acc_t e;
    e.word = w;
    e.pc4  = p;
    e.cnt  = c;
    exp_acc_q.push_back(e);
  endtask

  task automatic check_reset_values();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc4", instr_pc4, 32'd0);
    check("rst_count", fetch_count, 32'd0);
  endtask

  // Memory model: acks after ack_delay request cycles; force_ack injects a stray ack.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req === 1'b1) begin
        if (req_cnt >= ack_delay) begin
          imem_ack = 1'b1;
          req_cnt  = 0;
        end else begin
          imem_ack = 1'b0;
          req_cnt++;
        end
      end else begin
        imem_ack = force_ack;
        req_cnt  = 0;
      end
      imem_rdata = mem_word(imem_addr);
    end
  end

  // Monitor: every acked request and every accepted word is checked against the queues.
  initial begin
    acc_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_ack === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected actual=%h expected=none", imem_addr);
        end else begin
          a = exp_addr_q.pop_front();
          check("req_addr", imem_addr, a);
        end
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1 && redirect === 1'b0) begin
        if (exp_acc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL word_unexpected actual=%h expected=none", instr);
        end else begin
          e = exp_acc_q.pop_front();
          check("acc_instr", instr, e.word);
          check("acc_pc4", instr_pc4, e.pc4);
          check("acc_count", fetch_count, e.cnt);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (3) cyc();
    @(negedge clk);
    check_reset_values();

    // Straight-line fetch with always-ack memory and ready=1.
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8); exp_addr_q.push_back(32'hC);
    push_acc(32'hA500_0000, 32'h4, 32'd0);
    push_acc(32'hA500_0004, 32'h8, 32'd1);
    push_acc(32'hA500_0008, 32'hC, 32'd2);
    cyc(); rst = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      check("req_alternate", {31'd0, imem_req}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    cyc(); instr_ready = 1'b0;
    @(negedge clk);
    check("count_after3", fetch_count, 32'd3);

    // Backpressure for 5 cycles.
    push_acc(32'hA500_000C, 32'h10, 32'd3);
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_instr", instr, 32'hA500_000C);
      check("bp_pc4", instr_pc4, 32'h10);
      check("bp_req", {31'd0, imem_req}, 32'd0);
    end
    cyc(); instr_ready = 1'b1;
    exp_addr_q.push_back(32'h10);
    cyc(); instr_ready = 1'b0;
    @(negedge clk);
    check("bp_next_req", {31'd0, imem_req}, 32'd1);
    check("bp_next_addr", imem_addr, 32'h10);

    // Redirect in HOLD together with ready; unaligned target.
    cyc(); instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    exp_addr_q.push_back(32'h100);
    @(negedge clk);
    check("hold_rd_count", fetch_count, 32'd4);
    cyc(); instr_ready = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("hold_rd_req", {31'd0, imem_req}, 32'd1);
    check("hold_rd_addr", imem_addr, 32'h100);
    check("hold_rd_count2", fetch_count, 32'd4);

    // Jump at 0x00400000 -> 0x00000040.
    cyc(); redirect = 1'b1; redirect_pc = 32'h0040_0000;
    exp_addr_q.push_back(32'h0040_0000);
    push_acc(32'h0800_0010, 32'h0040_0004, 32'd4);
    exp_addr_q.push_back(32'h40);
    @(negedge clk);
    check("held_instr", instr, 32'hA500_0100);
    check("held_pc4", instr_pc4, 32'h104);
    cyc(); redirect = 1'b0;
    cyc(); instr_ready = 1'b1;
    cyc(); instr_ready = 1'b0;
    @(negedge clk);
    check("jump_addr", imem_addr, 32'h40);

    // Jump at 0xF0000000 -> 0xF0000040.
    cyc(); redirect = 1'b1; redirect_pc = 32'hF000_0000;
    exp_addr_q.push_back(32'hF000_0000);
    push_acc(32'h0800_0010, 32'hF000_0004, 32'd5);
    exp_addr_q.push_back(32'hF000_0040);
    cyc(); redirect = 1'b0;
    cyc(); instr_ready = 1'b1;
    cyc(); instr_ready = 1'b0;
    @(negedge clk);
    check("jump_hi_addr", imem_addr, 32'hF000_0040);
    check("count_after_jumps", fetch_count, 32'd6);

    // Redirect while a slow request is outstanding.
    cyc(); ack_delay = 3; redirect = 1'b1; redirect_pc = 32'h200;
    exp_addr_q.push_back(32'h200);
    exp_addr_q.push_back(32'h100);
    cyc(); redirect_pc = 32'h100; instr_ready = 1'b1;
    @(negedge clk);
    check("drain_addr0", imem_addr, 32'h200);
    cyc(); redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      if (k == 2) ack_delay = 0;
      @(negedge clk);
      check("drain_valid", {31'd0, instr_valid}, 32'd0);
      check("drain_req", {31'd0, imem_req}, 32'd1);
      check("drain_addr", imem_addr, 32'h200);
    end
    cyc(); instr_ready = 1'b0;
    @(negedge clk);
    check("after_drain_valid", {31'd0, instr_valid}, 32'd0);
    check("after_drain_addr", imem_addr, 32'h100);
    check("after_drain_count", fetch_count, 32'd6);

    // Reset while in DRAIN.
    cyc(); ack_delay = 5; redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    check("pre_rst_instr", instr, 32'hA500_0100);
    cyc(); redirect_pc = 32'h400;
    cyc(); redirect = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("drain_hold_addr", imem_addr, 32'h300);
    cyc();
    @(negedge clk);
    check_reset_values();
    cyc(); rst = 1'b0; force_ack = 1'b1; ack_delay = 0;
    exp_addr_q.push_back(32'h0);
    push_acc(32'hA500_0000, 32'h4, 32'd0);
    exp_addr_q.push_back(32'h4);
    @(negedge clk);
    check("idle_ack_req", {31'd0, imem_req}, 32'd0);
    check("idle_ack_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); force_ack = 1'b0;
    @(negedge clk);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    cyc(); instr_ready = 1'b1;
    cyc(); instr_ready = 1'b0;
    @(negedge clk);
    check("restart_count", fetch_count, 32'd1);
    repeat (3) cyc();
    @(negedge clk);
    check("addr_q_left", exp_addr_q.size(), 32'd0);
    check("acc_q_left", exp_acc_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Single-outstanding instruction fetch unit that produces the 32-bit instruction words whose op field (bits 31:26) drives the main control decoder. Walks the PC, issues requests to instruction memory over a req/ack handshake, and hands each word to decode over a valid/ready handshake. Resolves `j` (op 6'b000010) locally. Accepts a redirect (taken branch, exception) from downstream.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1
- imem_ack  in  1  memory response valid this cycle (only meaningful while imem_req=1)
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr_valid  out  1  instr/instr_pc4 hold a word for decode
- instr_ready  in  1  decode accepts the word this cycle
- instr  out  32  instruction word; op = instr[31:26]
- instr_pc4  out  32  address of instr + 4
- redirect  in  1  discard in-flight/held work, restart at redirect_pc
- redirect_pc  in  32  new fetch address; bits 1:0 ignored (forced 0)
- fetch_count  out  32  count of words accepted by decode, wraps at 2^32

## Operation
- One clock domain, synchronous active-high reset; every register is reset on a clk edge while rst=1.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: entered on reset; exactly one cycle, then REQ at pc=RESET_PC.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: capture imem_rdata into instr, instr_pc4=pc+4, go to HOLD.
- Next PC captured with the word: if imem_rdata[31:26]=6'b000010, next_pc={pc4[31:28], imem_rdata[25:0], 2'b00}. Otherwise pc+4. There is no delay slot.
- HOLD: instr_valid=1. On instr_ready: fetch_count+1, pc=next_pc, go to REQ.
- DRAIN: imem_req stays 1 at the old address until imem_ack. The returned word is discarded (never presented). Then go to REQ at the saved redirect address.
- Redirect priority is above everything else. All PC arithmetic is modulo 2^32.
  - REQ with imem_ack in the same cycle: the word is discarded; go to REQ at redirect_pc.
  - REQ without imem_ack: save redirect_pc; go to DRAIN.
  - HOLD: the held word is dropped even if instr_ready=1 that cycle, and fetch_count does not increment. Go to REQ at redirect_pc.
  - DRAIN: overwrite the saved address. The latest redirect wins.
  - IDLE: pc=redirect_pc; go to REQ.
- Reset mid-operation abandons any outstanding request. Instruction memory is reset by the same rst, and imem_ack is ignored outside REQ/DRAIN.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr=0, instr_pc4=0
  - fetch_count=0, state=IDLE
- First imem_req=1 appears in the second cycle after rst deasserts.
- imem_ack in cycle N gives instr_valid=1 in cycle N+1.
- instr_ready in cycle M gives imem_req=1 with the new address in cycle M+1.
- Peak throughput is one instruction per 2 cycles: ack in the same cycle as req, ready in the same cycle as valid.
- instr and instr_pc4 are stable while instr_valid=1 and instr_ready=0.
- Redirect in cycle K gives imem_req at redirect_pc in cycle K+1. From DRAIN it appears in the cycle after the draining ack.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset then always-ack memory, ready=1, RESET_PC=0:
  - addresses 0x0, 0x4, 0x8 are requested on alternate cycles;
  - fetch_count=3 after the third acceptance;
  - instr_pc4 = 0x4, 0x8, 0xC.
- Backpressure: hold instr_ready=0 for 5 cycles.
  - instr and instr_valid are stable and imem_req=0 throughout;
  - one cycle after ready, imem_addr is the next address.
- Jump: word 0x08000010 fetched at 0x00400000 → next request at 0x00000040.
  - At pc=0xF0000000 → next request at 0xF0000040.
- Redirect while imem_req=1 with ack delayed 3 cycles, redirect_pc=0x100:
  - the late word is never valid;
  - the next request is 0x100;
  - fetch_count is unchanged.
- Redirect in HOLD in the same cycle as instr_ready=1:
  - the word is dropped and fetch_count is unchanged;
  - the next imem_addr is redirect_pc.
  - Also: redirect_pc=0x103 is requested as 0x100.
- rst asserted while in DRAIN:
  - all outputs return to reset values;
  - an ack arriving during IDLE is ignored;
  - the fetch at RESET_PC proceeds normally.
